chacha_axil_loader: RTL and testbench

CHACHA_AXIL_LOADER -- requirements
Module: chacha_axil_loader

---
 rtl/chacha_axil_pkg.sv | 33 +++
 rtl/chacha_axil_if.sv | 33 +++
 rtl/chacha_axil_beat.sv | 75 +++++++
 rtl/chacha_axil_loader.sv | 162 ++++++++++++++++
 tb/tb_chacha_axil_loader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_axil_pkg.sv
// Shared definitions for the ChaCha20 AXI4-Lite key loader: register map,
// FSM encodings and error codes.
package chacha_axil_pkg;

   localparam logic [7:0] OFF_VERSION   = 8'h00;
   localparam logic [7:0] OFF_CONTROL   = 8'h04;
   localparam logic [7:0] OFF_KEY       = 8'h08;
   localparam logic [7:0] OFF_IV        = 8'h28;
   localparam logic [7:0] OFF_DATA_SIZE = 8'h34;

   localparam logic [31:0] EXPECTED_VERSION_DEF = 32'h1000_0000;

   localparam int KEY_WORDS = 8;
   localparam int IV_WORDS  = 3;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_RESP    = 2'd1;
   localparam logic [1:0] ERR_VERSION = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      IDLE, WR_CTRL0, WR_KEY, WR_IV, WR_CTRL1, RD_VER, POLL, FINISH
   } state_t;

   typedef enum logic [2:0] {
      B_IDLE, B_AW_W, B_AW, B_W, B_B, B_AR, B_R
   } beat_state_t;

   function automatic logic [7:0] word_off(input logic [7:0] base, input logic [3:0] idx);
      return base + 8'({idx, 2'b00});
   endfunction

endpackage

// File: rtl/chacha_axil_if.sv
// AXI4-Lite bus bundle between the loader (master) and the target core (slave).
interface chacha_axil_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/chacha_axil_beat.sv
// Single-beat AXI4-Lite engine: accepts one read or write request in idle and
// pulses ack in the cycle its response handshakes (resp/rdata valid with ack).
module chacha_axil_beat
   import chacha_axil_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          ack,
   output logic [1:0]    resp,
   output logic [DW-1:0] rdata,
   chacha_axil_if.master bus
);

   beat_state_t   state, state_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= B_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_d;
         if (state == B_IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
         end
      end
   end

   // AW and W retire independently; B is only opened once both are gone.
   always_comb begin
      state_d = state;
      case (state)
         B_IDLE: if (req) state_d = wr ? B_AW_W : B_AR;
         B_AW_W:
            case ({bus.awready, bus.wready})
               2'b11:   state_d = B_B;
               2'b10:   state_d = B_W;
               2'b01:   state_d = B_AW;
               default: state_d = B_AW_W;
            endcase
         B_AW:    if (bus.awready) state_d = B_B;
         B_W:     if (bus.wready)  state_d = B_B;
         B_B:     if (bus.bvalid)  state_d = B_IDLE;
         B_AR:    if (bus.arready) state_d = B_R;
         B_R:     if (bus.rvalid)  state_d = B_IDLE;
         default: state_d = B_IDLE;
      endcase
   end

   always_comb begin
      bus.awaddr  = addr_q;
      bus.araddr  = addr_q;
      bus.wdata   = wdata_q;
      bus.wstrb   = '1;
      bus.awvalid = (state == B_AW_W) || (state == B_AW);
      bus.wvalid  = (state == B_AW_W) || (state == B_W);
      bus.bready  = (state == B_B);
      bus.arvalid = (state == B_AR);
      bus.rready  = (state == B_R);
      ack         = ((state == B_B) && bus.bvalid) || ((state == B_R) && bus.rvalid);
      resp        = (state == B_B) ? bus.bresp : bus.rresp;
      rdata       = bus.rdata;
   end

endmodule

// File: rtl/chacha_axil_loader.sv
// Loads a ChaCha20 key/IV into a memory-mapped core over AXI4-Lite, checks the
// core version and polls CONTROL until the core reports ready.
module chacha_axil_loader
   import chacha_axil_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter logic [31:0] EXPECTED_VERSION = EXPECTED_VERSION_DEF,
   parameter int POLL_LIMIT = 1024
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [95:0]  iv,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [1:0]   err_code,
   chacha_axil_if.master m_axi
);

   localparam int PW = $clog2(POLL_LIMIT + 1);

   state_t         state, state_d;
   logic [3:0]     idx;
   logic [PW-1:0]  poll_cnt;
   logic [255:0]   key_q;
   logic [95:0]    iv_q;
   logic [1:0]     err_d;
   logic           start_ok;

   logic                          req, wr, ack;
   logic [7:0]                    off;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
   logic [C_M_AXI_DATA_WIDTH-1:0] wdata, rdata;
   logic [1:0]                    resp;

   // FINISH already reports busy=0, so a start landing there is honoured too.
   assign start_ok = start && (state == IDLE || state == FINISH);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state    <= IDLE;
         idx      <= '0;
         poll_cnt <= '0;
         key_q    <= '0;
         iv_q     <= '0;
         err_code <= ERR_NONE;
         error    <= 1'b0;
      end else begin
         state    <= state_d;
         err_code <= err_d;
         if (start_ok) begin
            key_q <= key;
            iv_q  <= iv;
            error <= 1'b0;
         end else if (state_d == FINISH) begin
            error <= (err_d != ERR_NONE);
         end
         if (state_d != state)  idx <= '0;
         else if (ack)          idx <= idx + 4'd1;
         if (state_d == POLL && state != POLL)
            poll_cnt <= '0;
         else if (state == POLL && ack && state_d == POLL)
            poll_cnt <= poll_cnt + PW'(1);
      end
   end

   always_comb begin
      state_d = state;
      err_d   = err_code;
      case (state)
         IDLE: if (start_ok) begin
            state_d = WR_CTRL0;
            err_d   = ERR_NONE;
         end
         FINISH: begin
            state_d = IDLE;
            if (start_ok) begin
               state_d = WR_CTRL0;
               err_d   = ERR_NONE;
            end
         end
         default: if (ack) begin
            if (resp != 2'b00) begin
               state_d = FINISH;
               err_d   = ERR_RESP;
            end else begin
               case (state)
                  WR_CTRL0: state_d = WR_KEY;
                  WR_KEY:   if (idx == 4'(KEY_WORDS - 1)) state_d = WR_IV;
                  WR_IV:    if (idx == 4'(IV_WORDS - 1))  state_d = WR_CTRL1;
                  WR_CTRL1: state_d = RD_VER;
                  RD_VER:
                     if (rdata != EXPECTED_VERSION) begin
                        state_d = FINISH;
                        err_d   = ERR_VERSION;
                     end else begin
                        state_d = POLL;
                     end
                  POLL:
                     if (rdata[1]) begin
                        state_d = FINISH;
                     end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
                        state_d = FINISH;
                        err_d   = ERR_TIMEOUT;
                     end
                  default: state_d = state;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      busy  = !(state == IDLE || state == FINISH);
      done  = (state == FINISH);
      req   = 1'b0;
      wr    = 1'b0;
      off   = OFF_VERSION;
      wdata = '0;
      case (state)
         WR_CTRL0: begin req = 1'b1; wr = 1'b1; off = OFF_CONTROL; end
         WR_KEY: begin
            req   = 1'b1;
            wr    = 1'b1;
            off   = word_off(OFF_KEY, idx);
            wdata = key_q[{idx[2:0], 5'b0} +: 32];
         end
         WR_IV: begin
            req   = 1'b1;
            wr    = 1'b1;
            off   = word_off(OFF_IV, idx);
            wdata = iv_q[{idx[1:0], 5'b0} +: 32];
         end
         WR_CTRL1: begin req = 1'b1; wr = 1'b1; off = OFF_CONTROL; wdata = 32'd1; end
         RD_VER:   begin req = 1'b1; off = OFF_VERSION; end
         POLL:     begin req = 1'b1; off = OFF_CONTROL; end
         default:  req = 1'b0;
      endcase
      addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(off);
   end

   chacha_axil_beat #(
      .AW (C_M_AXI_ADDR_WIDTH),
      .DW (C_M_AXI_DATA_WIDTH)
   ) u_beat (
      .clk   (aclk),
      .rst   (areset),
      .req   (req),
      .wr    (wr),
      .addr  (addr),
      .wdata (wdata),
      .ack   (ack),
      .resp  (resp),
      .rdata (rdata),
      .bus   (m_axi)
   );

endmodule

// File: tb/tb_chacha_axil_loader.sv
// Directed bench: configurable AXI4-Lite responder, table of load scenarios,
// plus hand sequences for reset and mid-sequence reset.
module tb_chacha_axil_loader;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int          PLIM = 4;

   logic         aclk = 1'b0;
   logic         areset = 1'b1;
   logic         start = 1'b0;
   logic [255:0] key = '0;
   logic [95:0]  iv = '0;
   logic         busy, done, error;
   logic [1:0]   err_code;

   chacha_axil_if #(.AW(32), .DW(32)) bus ();

   chacha_axil_loader #(
      .BASE_ADDR  (BASE),
      .POLL_LIMIT (PLIM)
   ) dut (
      .aclk     (aclk),
      .areset   (areset),
      .start    (start),
      .key      (key),
      .iv       (iv),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .err_code (err_code),
      .m_axi    (bus)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [255:0] key;
      logic [95:0]  iv;
      int           aw_dly, w_dly, b_dly, bad_widx;
      logic [31:0]  ver;
      int           poll_at;
      bit           rbad, restart;
      int           exp_wr, exp_rd, exp_poll;
      logic [1:0]   exp_err;
   } vec_t;

   vec_t vt[7];

   int    checks = 0, errors = 0;
   string tag = "init";

   // responder configuration (written by the main sequence only)
   int          aw_dly = 0, w_dly = 0, b_dly = 0, bad_widx = -1, poll_at = 1;
   int          wbase = 0, pbase = 0;
   logic [31:0] ver_val = 32'h1000_0000;
   bit          rbad = 1'b0;

   // responder logs (written by the responder only)
   logic [31:0] wr_addr[$], wr_data[$];
   int          n_rd = 0, n_poll = 0, viol = 0, done_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [255:0] k, input logic [95:0] v,
                               input int ad, input int wd, input int bd, input int bw,
                               input logic [31:0] ver, input int pa, input bit rb, input bit rs,
                               input int ew, input int er, input int ep, input logic [1:0] ee);
      vec_t r;
      r.key = k; r.iv = v; r.aw_dly = ad; r.w_dly = wd; r.b_dly = bd; r.bad_widx = bw;
      r.ver = ver; r.poll_at = pa; r.rbad = rb; r.restart = rs;
      r.exp_wr = ew; r.exp_rd = er; r.exp_poll = ep; r.exp_err = ee;
      return r;
   endfunction

   // Reference write order: CONTROL=0, 8 key words, 3 IV words, CONTROL=1.
   function automatic void exp_write(input int k, input logic [255:0] kk, input logic [95:0] vv,
                                     output logic [31:0] a, output logic [31:0] d);
      if (k == 0) begin
         a = BASE + 32'h4; d = 32'h0;
      end else if (k <= 8) begin
         a = BASE + 32'h8 + 32'(4 * (k - 1)); d = kk[32 * (k - 1) +: 32];
      end else if (k <= 11) begin
         a = BASE + 32'h28 + 32'(4 * (k - 9)); d = vv[32 * (k - 9) +: 32];
      end else begin
         a = BASE + 32'h4; d = 32'h1;
      end
   endfunction

   // Responder: acts at negedge, so values seen here are the ones the next posedge samples.
   initial begin
      int          aw_wait, w_wait, b_wait;
      bit          aw_got, w_got, ar_got, both, rd_prev;
      logic [31:0] aw_hold, w_hold, rd_val;
      logic [1:0]  rd_resp;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_hold = '0; w_hold = '0; rd_val = '0; rd_resp = '0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
      forever begin
         @(negedge aclk);
         if (done === 1'b1) done_cnt++;
         if (areset) begin
            aw_wait = 0; w_wait = 0; b_wait = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
            bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
         end else begin
            both    = aw_got && w_got;
            rd_prev = ar_got;
            if (bus.bready && !both) viol++;
            if (bus.rready && !rd_prev) viol++;
            if (bus.arvalid && (aw_got || w_got || bus.awvalid || bus.wvalid)) viol++;
            if (bus.wvalid && bus.wstrb !== 4'hF) viol++;

            bus.awready = 0;
            if (bus.awvalid) begin
               if (aw_got) viol++;
               else begin
                  if (aw_wait == 0) aw_hold = bus.awaddr;
                  else if (bus.awaddr !== aw_hold) viol++;
                  if (aw_wait >= aw_dly) begin bus.awready = 1; aw_got = 1; end
                  aw_wait++;
               end
            end

            bus.wready = 0;
            if (bus.wvalid) begin
               if (w_got) viol++;
               else begin
                  if (w_wait == 0) w_hold = bus.wdata;
                  else if (bus.wdata !== w_hold) viol++;
                  if (w_wait >= w_dly) begin bus.wready = 1; w_got = 1; end
                  w_wait++;
               end
            end

            bus.bvalid = 0; bus.bresp = 0;
            if (both) begin
               if (b_wait >= b_dly) begin
                  bus.bvalid = 1;
                  bus.bresp  = (wr_addr.size() - wbase == bad_widx) ? 2'b10 : 2'b00;
                  if (bus.bready) begin
                     wr_addr.push_back(aw_hold);
                     wr_data.push_back(w_hold);
                     aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
                  end
               end else begin
                  b_wait++;
               end
            end

            bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
            if (rd_prev) begin
               bus.rvalid = 1; bus.rdata = rd_val; bus.rresp = rd_resp;
               if (bus.rready) ar_got = 0;
            end

            bus.arready = 0;
            if (bus.arvalid && !ar_got && !rd_prev) begin
               bus.arready = 1; ar_got = 1; n_rd++;
               if (bus.araddr == BASE) begin
                  rd_val = ver_val; rd_resp = rbad ? 2'b10 : 2'b00;
               end else if (bus.araddr == BASE + 32'h4) begin
                  n_poll++;
                  rd_val  = (poll_at != 0 && (n_poll - pbase) >= poll_at) ? 32'h3 : 32'h1;
                  rd_resp = 2'b00;
               end else begin
                  rd_val = 32'hDEAD_BEEF; rd_resp = 2'b00; viol++;
               end
            end
         end
      end
   end

   task automatic set_cfg(input vec_t v);
      aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly = v.b_dly; bad_widx = v.bad_widx;
      ver_val = v.ver; poll_at = v.poll_at; rbad = v.rbad;
      wbase = wr_addr.size(); pbase = n_poll;
   endtask

   task automatic run_vec(input vec_t v);
      int          cyc, w0, r0, p0, v0, d0, bad;
      logic [31:0] ea, ed;
      set_cfg(v);
      w0 = wr_addr.size(); r0 = n_rd; p0 = n_poll; v0 = viol; d0 = done_cnt;
      @(negedge aclk);
      key = v.key; iv = v.iv; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      chk("start_busy_clear", {busy, error, err_code}, 4'b1000);
      if (v.restart) begin
         key = ~v.key; iv = ~v.iv;
         repeat (3) @(negedge aclk);
         start = 1'b1;
         @(negedge aclk);
         start = 1'b0;
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(negedge aclk);
         cyc++;
      end
      chk("done_seen", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      chk("err_code_at_done", err_code, v.exp_err);
      chk("error_at_done", error, v.exp_err != 2'd0);
      repeat (10) @(negedge aclk);
      chk("done_pulses", done_cnt - d0, 1);
      chk("error_sticky", {busy, error, err_code}, {1'b0, v.exp_err != 2'd0, v.exp_err});
      chk("n_writes", wr_addr.size() - w0, v.exp_wr);
      chk("n_reads", n_rd - r0, v.exp_rd);
      chk("n_polls", n_poll - p0, v.exp_poll);
      chk("protocol", viol - v0, 0);
      bad = 0;
      for (int k = 0; k < v.exp_wr && w0 + k < wr_addr.size(); k++) begin
         exp_write(k, v.key, v.iv, ea, ed);
         if (wr_addr[w0 + k] !== ea || wr_data[w0 + k] !== ed) bad++;
      end
      chk("write_log", bad, 0);
   endtask

   initial begin
      logic [255:0] k0;
      logic [95:0]  i0;
      int           s, cyc, d0;
      for (int b = 0; b < 32; b++) k0[8 * b +: 8] = 8'(b);
      for (int b = 0; b < 12; b++) i0[8 * b +: 8] = 8'(b);

      vt[0] = mk(k0, i0, 0, 0, 0, -1, 32'h1000_0000, 1, 0, 0, 13, 2, 1, 2'd0);
      vt[1] = mk(k0 ^ {8{32'hA5A5_5A5A}}, ~i0, 3, 0, 2, -1, 32'h1000_0000, 1, 0, 1, 13, 2, 1, 2'd0);
      vt[2] = mk(k0, i0, 0, 0, 0, 10, 32'h1000_0000, 1, 0, 0, 11, 0, 0, 2'd1);
      vt[3] = mk(k0, i0, 0, 0, 0, -1, 32'h2000_0000, 1, 0, 0, 13, 1, 0, 2'd2);
      vt[4] = mk(k0, i0, 0, 0, 0, -1, 32'h1000_0000, 0, 0, 0, 13, 5, 4, 2'd3);
      vt[5] = mk({8{32'h0123_4567}}, {3{32'h89AB_CDEF}}, 0, 2, 1, -1, 32'h1000_0000, 4, 0, 0, 13, 5, 4, 2'd0);
      vt[6] = mk(k0, i0, 0, 0, 0, -1, 32'h1000_0000, 1, 1, 0, 13, 1, 0, 2'd1);

      tag = "reset";
      repeat (3) @(negedge aclk);
      chk("outputs", {busy, done, error, err_code, bus.awvalid, bus.wvalid, bus.bready,
                      bus.arvalid, bus.rready}, 0);
      chk("addr_data", {bus.awaddr, bus.wdata}, 0);
      areset = 1'b0;
      repeat (2) @(negedge aclk);

      for (int i = 0; i < 7; i++) begin
         tag = $sformatf("vec%0d", i);
         s = wr_addr.size();
         run_vec(vt[i]);
         if (i == 0) begin
            chk("key_word0", {wr_addr[s + 1], wr_data[s + 1]}, {BASE + 32'h8, 32'h0302_0100});
            chk("ctrl_final", {wr_addr[s + 12], wr_data[s + 12]}, {BASE + 32'h4, 32'h1});
         end
      end

      // reset while a key word write is in flight
      tag = "rst_mid";
      set_cfg(vt[0]);
      s = wr_addr.size();
      @(negedge aclk);
      key = k0; iv = i0; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      cyc = 0;
      while ((wr_addr.size() - s < 3 || bus.awvalid !== 1'b1) && cyc < 500) begin
         @(negedge aclk);
         cyc++;
      end
      chk("reached_wr_key", cyc < 500, 1'b1);
      d0 = done_cnt;
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      chk("outputs", {busy, done, error, err_code, bus.awvalid, bus.wvalid, bus.bready,
                      bus.arvalid, bus.rready}, 0);
      chk("addr_data", {bus.awaddr, bus.araddr, bus.wdata}, 0);
      areset = 1'b0;
      repeat (20) @(negedge aclk);
      chk("no_done", done_cnt - d0, 0);
      chk("idle_after", {busy, error, err_code}, 0);

      tag = "rerun";
      run_vec(vt[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
